// File: rtl/isp1362_bus_sequencer.sv
// Timed ISP1362 parallel-bus cycle engine: one Avalon-style request becomes one bus cycle.
// Define ISP1362_PORST_EN to add a power-on OTG_RST_N pulse (PORST state) after reset release.
module isp1362_bus_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 6,
  parameter int RST_CYC    = 1000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iCS_N,
  input  logic        iRD_N,
  input  logic        iWR_N,
  input  logic        iADDR,
  input  logic        iSEL_DC,
  input  logic [15:0] iDATA,
  output logic [15:0] oDATA,
  output logic        oWAIT,
  output logic [1:0]  OTG_ADDR,
  output logic        OTG_CS_N,
  output logic        OTG_RD_N,
  output logic        OTG_WR_N,
  output logic        OTG_RST_N,
  inout  wire  [15:0] OTG_DATA
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_RECOV, S_PORST
  } state_t;

  localparam logic [15:0] L_SETUP  = 16'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
  localparam logic [15:0] L_STROBE = 16'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
  localparam logic [15:0] L_HOLD   = 16'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);
  localparam logic [15:0] L_RECOV  = 16'((RECOV_CYC  > 0) ? RECOV_CYC  - 1 : 0);
  localparam logic [15:0] L_RST    = 16'((RST_CYC    > 0) ? RST_CYC    - 1 : 0);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [1:0]  r_addr;
  logic        r_dir;
  logic        r_csN;
  logic        r_rdN;
  logic        r_wrN;
  logic        r_rstN;
  logic        r_drive;
  logic        r_wait;
  logic        w_req;
  logic        w_accept;
  logic        w_dirWr;
  logic        w_busy;
  logic        w_strobe;
  logic [15:0] w_load;

  assign w_req    = !iCS_N && (!iRD_N || !iWR_N);
  assign w_accept = (r_state == S_IDLE) && w_req;
  // Direction of the cycle being entered: taken live on the accept edge, latched afterwards.
  assign w_dirWr  = w_accept ? !iWR_N : r_dir;
  assign w_busy   = (w_next == S_SETUP) || (w_next == S_STROBE) || (w_next == S_HOLD);
  assign w_strobe = (w_next == S_STROBE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = (SETUP_CYC > 0) ? S_SETUP : S_STROBE;
      S_SETUP:  if (r_cnt == 16'd0) w_next = S_STROBE;
      S_STROBE: if (r_cnt == 16'd0) w_next = (HOLD_CYC > 0) ? S_HOLD : S_DONE;
      S_HOLD:   if (r_cnt == 16'd0) w_next = S_DONE;
      S_DONE:   w_next = (RECOV_CYC > 0) ? S_RECOV : S_IDLE;
      S_RECOV:  if (r_cnt == 16'd0) w_next = S_IDLE;
`ifdef ISP1362_PORST_EN
      S_PORST:  if (r_cnt == 16'd0) w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 16'd0;
    case (w_next)
      S_SETUP:  w_load = L_SETUP;
      S_STROBE: w_load = L_STROBE;
      S_HOLD:   w_load = L_HOLD;
      S_RECOV:  w_load = L_RECOV;
      default:  w_load = 16'd0;
    endcase
  end

  // Pin outputs are computed from the state being entered so they line up with the state register.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
`ifdef ISP1362_PORST_EN
      r_state <= S_PORST;
      r_cnt   <= L_RST;
`else
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
`endif
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
      r_addr  <= 2'b00;
      r_dir   <= 1'b0;
      r_csN   <= 1'b1;
      r_rdN   <= 1'b1;
      r_wrN   <= 1'b1;
      r_rstN  <= 1'b0;
      r_drive <= 1'b0;
      r_wait  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= w_load;
      else if (r_cnt != 16'd0)
        r_cnt <= r_cnt - 16'd1;

      if (w_accept) begin
        r_dir   <= !iWR_N;
        r_addr  <= {iSEL_DC, iADDR};
        r_wdata <= iDATA;
      end

      if ((r_state == S_STROBE) && (r_cnt == 16'd0) && !r_dir)
        r_rdata <= OTG_DATA;

      r_csN   <= !w_busy;
      r_rdN   <= !(w_strobe && !w_dirWr);
      r_wrN   <= !(w_strobe && w_dirWr);
      r_drive <= w_busy && w_dirWr;
      r_wait  <= (w_next != S_DONE);

`ifdef ISP1362_PORST_EN
      if ((r_state == S_PORST) && (r_cnt == 16'd0))
        r_rstN <= 1'b1;
`else
      r_rstN <= 1'b1;
`endif
    end
  end

  assign oDATA     = r_rdata;
  assign oWAIT     = r_wait;
  assign OTG_ADDR  = r_addr;
  assign OTG_CS_N  = r_csN;
  assign OTG_RD_N  = r_rdN;
  assign OTG_WR_N  = r_wrN;
  assign OTG_RST_N = r_rstN;
  assign OTG_DATA  = r_drive ? r_wdata : 16'hzzzz;

endmodule
